fetch_unit: RTL and testbench

Instruction-fetch stage of the core: owns the program counter, issues one-at-a-time requests to instruction memory over a req/gnt/rvalid handshake, and presents fetched instructions to decode through a valid/stall output register. It sits downstream of `branch_unit` and the jump logic. It consumes `branch_taken` plus the resolved target and redirects the PC. When it redirects, it squashes the instruction it holds and any request still in flight, and raises `flush` for younger pipeline stages.

---
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single outstanding imem requests,
// presents fetched words to decode and squashes stale work on branch/jump redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        flush
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc_inflight;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_instr;
    logic            r_flush;

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic            w_req;
    logic            w_fire;
    logic            w_capture;

    // The branch is the older instruction, so it wins over a simultaneous jump.
    assign w_redirect = branch_taken || jump;
    assign w_target   = (branch_taken ? branch_target : jump_target) & ALIGN_MASK;
    assign w_fire     = w_req && imem_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A grant or outstanding response that coincides with a redirect is stale and drained.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_FETCH;
            S_FETCH: begin
                if (w_fire) begin
                    w_state_next = w_redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_next = S_FETCH;
                end else if (w_redirect) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req     = 1'b0;
        w_capture = 1'b0;
        if (r_state == S_FETCH) begin
            w_req = !r_if_valid || !stall;
        end
        if (r_state == S_WAIT) begin
            w_capture = imem_rvalid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_pc_inflight <= '0;
            r_if_valid    <= 1'b0;
            r_if_pc       <= '0;
            r_if_instr    <= NOP_INSTR;
            r_flush       <= 1'b0;
        end else begin
            r_flush <= w_redirect;

            if (w_redirect) begin
                r_pc <= w_target;
            end else if (w_fire) begin
                r_pc <= r_pc + PC_STEP;
            end

            if (w_fire) begin
                r_pc_inflight <= r_pc;
            end

            // Redirect squashes the slot even if decode is stalled or data lands now.
            if (w_redirect) begin
                r_if_valid <= 1'b0;
            end else if (w_capture) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_pc_inflight;
                r_if_instr <= imem_rdata;
            end else if (r_if_valid && !stall) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign imem_req       = w_req;
    assign imem_addr      = r_pc;
    assign if_valid       = r_if_valid;
    assign if_pc          = r_if_pc;
    assign if_instruction = r_if_instr;
    assign flush          = r_flush;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model returns addr+1, expected
// (pc, instruction) pairs are queued per scenario and checked as they appear.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        flush;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .flush          (flush)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          flush_cnt = 0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_ins_q[$];

    // memory knobs
    logic [31:0] stop_addr = 32'h0000_0001;
    logic [31:0] slow_addr = 32'h0000_0001;
    int          lat = 0;
    logic        inject = 1'b0;

    logic        fired = 1'b0;
    logic [31:0] faddr = '0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    logic        prev_valid = 1'b0;
    logic        prev_stall = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign imem_gnt = imem_req && (imem_addr != stop_addr);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_pc_q.push_back(pc);
        exp_ins_q.push_back(pc + 32'd1);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_pc_q.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        check("sb_drain", 32'(exp_pc_q.size()), 32'd0);
    endtask

    // Memory model: grant is combinational, data follows lat cycles after the grant cycle.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            fired = imem_req && imem_gnt;
            faddr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (fired) begin
                pend  = 1'b1;
                paddr = faddr;
                cnt   = (faddr == slow_addr) ? 3 : lat;
            end
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = paddr + 32'd1;
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (inject) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
                inject      = 1'b0;
            end
        end
    end

    // A slot is newly filled when valid now and it was not being held by stall before.
    always @(negedge clk) begin
        if (rst_n && if_valid && !(prev_valid && prev_stall)) begin
            if (exp_pc_q.size() == 0) begin
                check("sb_unexpected", {31'b0, if_valid}, 32'd0);
            end else begin
                check("sb_pc", if_pc, exp_pc_q.pop_front());
                check("sb_instr", if_instruction, exp_ins_q.pop_front());
            end
        end
        if (rst_n && flush) flush_cnt++;
        prev_valid = if_valid;
        prev_stall = stall;
    end

    task automatic do_reset();
        rst_n         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        stall         = 1'b0;
        inject        = 1'b0;
        lat           = 0;
        slow_addr     = 32'h0000_0001;
        exp_pc_q.delete();
        exp_ins_q.delete();
        tick(2);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instruction, 32'h0000_0013);
        check("rst_flush", {31'b0, flush}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0000_0100);
    endtask

    initial begin
        int n;

        // Sequential fetch after reset release with zero-wait memory
        do_reset();
        stop_addr = 32'h0000_010C;
        push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
        rst_n = 1'b1;
        tick(1);
        check("s1_req_first", {31'b0, imem_req}, 32'd1);
        check("s1_addr_first", imem_addr, 32'h100);
        tick(1);
        check("s1_wait_req", {31'b0, imem_req}, 32'd0);
        check("s1_valid_early", {31'b0, if_valid}, 32'd0);
        tick(1);
        check("s1_valid_lat", {31'b0, if_valid}, 32'd1);
        tick(2);
        check("s1_thru_valid", {31'b0, if_valid}, 32'd1);
        check("s1_thru_pc", if_pc, 32'h104);
        wait_empty();
        tick(2);
        check("s1_stop_addr", imem_addr, 32'h10C);
        check("s1_flush_none", 32'(flush_cnt), 32'd0);

        // Stall holds the slot at 0x104 and blocks requests
        do_reset();
        stop_addr = 32'h0000_010C;
        push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
        rst_n = 1'b1;
        n = 0;
        while (!(if_valid && if_pc == 32'h104) && n < 40) begin tick(1); n++; end
        check("s2_reach_104", 32'(n < 40), 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("s2_hold_valid", {31'b0, if_valid}, 32'd1);
            check("s2_hold_pc", if_pc, 32'h104);
            check("s2_hold_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick(2);
        check("s2_rel_valid", {31'b0, if_valid}, 32'd1);
        check("s2_rel_pc", if_pc, 32'h108);
        wait_empty();

        // Branch while waiting on a slow response for 0x10C
        do_reset();
        stop_addr = 32'h0000_0204;
        slow_addr = 32'h0000_010C;
        push_exp(32'h100); push_exp(32'h104); push_exp(32'h108); push_exp(32'h200);
        rst_n = 1'b1;
        n = 0;
        while (!(imem_addr == 32'h110 && !imem_req) && n < 40) begin tick(1); n++; end
        check("s3_reach_wait", 32'(n < 40), 32'd1);
        flush_cnt = 0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0200;
        tick(1);
        branch_taken = 1'b0;
        check("s3_flush_hi", {31'b0, flush}, 32'd1);
        check("s3_addr_tgt", imem_addr, 32'h200);
        check("s3_drain_req", {31'b0, imem_req}, 32'd0);
        tick(1);
        check("s3_flush_lo", {31'b0, flush}, 32'd0);
        wait_empty();
        check("s3_flush_once", 32'(flush_cnt), 32'd1);

        // Branch and jump together, coinciding with a grant
        do_reset();
        stop_addr = 32'h0000_0304;
        push_exp(32'h100); push_exp(32'h300);
        rst_n = 1'b1;
        n = 0;
        while (!(imem_req && imem_addr == 32'h104) && n < 40) begin tick(1); n++; end
        check("s4_reach_req", 32'(n < 40), 32'd1);
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0300;
        jump          = 1'b1;
        jump_target   = 32'h0000_0400;
        tick(1);
        branch_taken = 1'b0;
        jump         = 1'b0;
        check("s4_addr_prio", imem_addr, 32'h300);
        check("s4_drain_req", {31'b0, imem_req}, 32'd0);
        check("s4_squash", {31'b0, if_valid}, 32'd0);
        check("s4_flush", {31'b0, flush}, 32'd1);
        wait_empty();

        // Jump to an unaligned top address, then PC wraps to zero
        do_reset();
        stop_addr = 32'h0000_0004;
        push_exp(32'hFFFF_FFFC); push_exp(32'h0000_0000);
        rst_n = 1'b1;
        n = 0;
        while (!(imem_req && imem_addr == 32'h100) && n < 40) begin tick(1); n++; end
        check("s5_reach_req", 32'(n < 40), 32'd1);
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFE;
        tick(1);
        jump = 1'b0;
        check("s5_addr_align", imem_addr, 32'hFFFF_FFFC);
        wait_empty();
        check("s5_wrap_addr", imem_addr, 32'h0000_0004);

        // Reset asserted while waiting; responses during and after reset are ignored
        do_reset();
        stop_addr = 32'h0000_0108;
        lat = 2;
        rst_n = 1'b1;
        n = 0;
        while (!(imem_addr == 32'h104 && !imem_req) && n < 40) begin tick(1); n++; end
        check("s6_reach_wait", 32'(n < 40), 32'd1);
        rst_n = 1'b0;
        #1;
        check("s6_async_addr", imem_addr, 32'h100);
        check("s6_async_req", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("s6_rst_valid", {31'b0, if_valid}, 32'd0);
        end
        lat = 0;
        flush_cnt = 0;
        push_exp(32'h100); push_exp(32'h104);
        rst_n  = 1'b1;
        inject = 1'b1;
        wait_empty();
        check("s6_flush_none", 32'(flush_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
